mem_responder: RTL
==================

# mem_responder

Memory-side responder for the multicycle processor's shared instruction/data memory port. It accepts the single-beat read/write strobes that the control unit issues during fetch, load and store states. It performs word accesses on an internal word array after a programmable number of wait states, and returns a one-cycle `memReady` pulse with registered read data. It replaces the ideal zero-latency memory model so that the datapath can be run against realistic latency.

## Interface
- `DATA_W`, 32, data word width in bits
- `ADDR_W`, 32, byte-address width
- `DEPTH`, 1024, number of words in the array; legal byte addresses are 0 .. 4*DEPTH-1
- `WAIT`, 2, wait states between request capture and response (0..15)

- `clk`  in  1  system clock; all state changes on rising edge
- `rst`  in  1  reset: one clock; reset is synchronous and active-high
- `memRead`  in  1  read request strobe
- `memWrite`  in  1  write request strobe
- `Adr`  in  ADDR_W  byte address, from the IorD mux
- `WriteData`  in  DATA_W  store data
- `ReadData`  out  DATA_W  registered read data; holds until the next successful read
- `memReady`  out  1  one-cycle response pulse (read data valid / write committed / error)
- `memErr`  out  1  qualifies `memReady`: access rejected
- `busy`  out  1  high from the cycle after capture through the `memReady` cycle

## Operation
- States: IDLE, WAIT, RESP.
- IDLE: on a rising edge where `memRead|memWrite`=1, capture `Adr`, `WriteData` and direction. Load the wait counter with `WAIT`. Go to WAIT, or straight to RESP when `WAIT`=0.
- WAIT: decrement the counter each cycle. When the counter is 1, the next state is RESP. Input strobes and bus values are ignored in this state.
- Entry into RESP, on the same edge:
  - Perform the array access using the captured address.
  - Read: `ReadData` <= word at `Adr[log2(DEPTH)+1:2]`.
  - Write: that word <= captured `WriteData`.
- RESP: `memReady`=1 for exactly one cycle, then return to IDLE. Strobes present during RESP are not sampled. A new request is accepted at the earliest in the following IDLE cycle.
- Error checks, evaluated on the captured request:
  - `Adr[1:0]`≠00, address ≥ 4*DEPTH, or `memRead` and `memWrite` both high.
  - On error: no array access, `ReadData` unchanged, `memReady`=1 and `memErr`=1 in RESP.
- `memErr` is 0 whenever `memReady` is 0.
- The array is not cleared by reset. It may be preloaded from a hex file by simulation initialization only.
- Address arithmetic: word index = `Adr>>2`. Upper address bits beyond the range check are not aliased.

## Timing
- Reset values: state IDLE, `ReadData`=0, `memReady`=0, `memErr`=0, `busy`=0, counter=0.
- Latency: a request sampled at edge N gives `memReady` high during cycle N+WAIT+1. For `WAIT`=0 it is high in the cycle right after sampling.
- Throughput: one access per WAIT+2 cycles when requests are back-to-back.
- `busy` rises the cycle after capture and falls together with `memReady`.
- Reset mid-operation (in WAIT or RESP) aborts the access:
  - No write is committed unless the RESP-entry edge has already occurred.
  - Outputs return to reset values on the next edge.
- Strobe held high continuously: exactly one access per IDLE visit. There is no duplicate access caused by a level-held strobe.
- Counter width is 4 bits. `WAIT`>15 is illegal and is flagged by an elaboration-time check.

## Test plan
- Reset then idle, `WAIT`=2 → `ReadData`=0, `memReady`=0, `busy`=0 for 10 cycles.
- Write 0xDEADBEEF to `Adr`=0x10, then read 0x10 → each `memReady` pulse arrives 3 cycles after its strobe. After the read, `ReadData`=0xDEADBEEF and `memErr`=0.
- `WAIT`=0, back-to-back reads of 0x0 and 0x4 preloaded with 0x11111111 and 0x22222222:
  - `memReady` arrives in cycles 1 and 3.
  - `ReadData` is 0x11111111, then 0x22222222.
- Misaligned read `Adr`=0x6 and out-of-range write `Adr`=0x1000 (`DEPTH`=1024):
  - `memReady`=1 and `memErr`=1 for each.
  - `ReadData` is unchanged and word 0 is unchanged.
- `memRead` and `memWrite` both high at `Adr`=0x8 → error response, word 2 unchanged.
- Write 0xCAFEF00D to 0x20 with reset asserted during the second WAIT cycle:
  - No `memReady` pulse.
  - A later read of 0x20 returns the prior contents.
  - All outputs are 0 on the cycle after reset.

Source files
------------

// File: rtl/mem_responder.sv
// mem_responder: wait-stated word memory behind the multicycle CPU's shared memory port
// Ports: clk/rst (sync, active-high); memRead/memWrite/Adr/WriteData request inputs;
// ReadData (registered read data), memReady (one-cycle response), memErr (rejected access), busy.
module mem_responder #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 1024,
    parameter int WAIT   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              memRead,
    input  logic              memWrite,
    input  logic [ADDR_W-1:0] Adr,
    input  logic [DATA_W-1:0] WriteData,
    output logic [DATA_W-1:0] ReadData,
    output logic              memReady,
    output logic              memErr,
    output logic              busy
);
    localparam int IW = $clog2(DEPTH);
    if (WAIT < 0 || WAIT > 15) begin : g_wait_chk
        $error("mem_responder: WAIT must be 0..15");
    end
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
    state_t            r_state;
    logic [3:0]        r_cnt;
    logic [IW-1:0]     r_idx;
    logic [DATA_W-1:0] r_wdata;
    logic              r_wr;
    logic              r_err;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic              w_idle;
    logic              w_req;
    logic              w_in_err;
    logic              w_go;
    logic              w_wr;
    logic              w_err;
    logic [IW-1:0]     w_idx;
    logic [DATA_W-1:0] w_wdata;
    // With WAIT=0 the access happens on the capture edge itself, so the live
    // bus values stand in for the captured ones while in IDLE.
    always_comb begin
        w_idle   = r_state == S_IDLE;
        w_req    = memRead | memWrite;
        w_in_err = (Adr[1:0] != 2'b00) || ((Adr >> 2) >= ADDR_W'(DEPTH)) || (memRead && memWrite);
        w_go     = (w_idle && w_req && WAIT == 0) || (r_state == S_WAIT && r_cnt == 4'd1);
        w_wr     = w_idle ? memWrite : r_wr;
        w_err    = w_idle ? w_in_err : r_err;
        w_idx    = w_idle ? Adr[IW+1:2] : r_idx;
        w_wdata  = w_idle ? WriteData : r_wdata;
    end
    // Array has no reset; a reset on the RESP-entry edge suppresses the commit.
    always_ff @(posedge clk) begin
        if (w_go && w_wr && !w_err && !rst) r_mem[w_idx] <= w_wdata;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= 4'd0;
            ReadData <= '0;
            memReady <= 1'b0;
            memErr   <= 1'b0;
            busy     <= 1'b0;
        end else begin
            memReady <= w_go;
            memErr   <= w_go && w_err;
            if (w_go && !w_err && !w_wr) ReadData <= r_mem[w_idx];
            case (r_state)
                S_IDLE: if (w_req) begin
                    r_idx   <= Adr[IW+1:2];
                    r_wdata <= WriteData;
                    r_wr    <= memWrite;
                    r_err   <= w_in_err;
                    r_cnt   <= 4'(WAIT);
                    busy    <= 1'b1;
                    r_state <= (WAIT == 0) ? S_RESP : S_WAIT;
                end
                S_WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) r_state <= S_RESP;
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule
